// File: rtl/fir_bram_sequencer_if.sv
// Control, AXI-Stream and BRAM signals of the FIR sequencer.
// The master modport is the sequencer's view; slave is the view of everything around it.
interface fir_bram_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ap_start;
  logic [31:0]           data_length;
  logic                  ap_idle;
  logic                  ap_done;
  logic                  stream_err;

  logic                  ss_tvalid;
  logic [DATA_WIDTH-1:0] ss_tdata;
  logic                  ss_tlast;
  logic                  ss_tready;

  logic                  sm_tvalid;
  logic [DATA_WIDTH-1:0] sm_tdata;
  logic                  sm_tlast;
  logic                  sm_tready;

  logic                  tap_re;
  logic [ADDR_WIDTH-1:0] tap_raddr;
  logic [DATA_WIDTH-1:0] tap_rdo;

  logic                  data_we;
  logic [ADDR_WIDTH-1:0] data_waddr;
  logic [DATA_WIDTH-1:0] data_wdi;
  logic                  data_re;
  logic [ADDR_WIDTH-1:0] data_raddr;
  logic [DATA_WIDTH-1:0] data_rdo;

  modport master (
    input  ap_start, data_length, ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_rdo, data_rdo,
    output ap_idle, ap_done, stream_err, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
           tap_re, tap_raddr, data_we, data_waddr, data_wdi, data_re, data_raddr
  );

  modport slave (
    output ap_start, data_length, ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_rdo, data_rdo,
    input  ap_idle, ap_done, stream_err, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
           tap_re, tap_raddr, data_we, data_waddr, data_wdi, data_re, data_raddr
  );
endinterface

// File: rtl/fir_bram_sequencer.sv
// FIR sequencer: stores stream samples in a circular data BRAM, sweeps tap/data BRAMs
// with a 1-cycle read latency, and streams out one wrapped 32-bit MAC result per sample.
module fir_bram_sequencer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_TAP    = 11
) (
  input logic                  axis_clk,
  input logic                  axis_rst_n,
  fir_bram_sequencer_if.master bus
);
  localparam int unsigned CntW = $clog2(NUM_TAP + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_TAP - 1);
  localparam logic [CntW-1:0] MacLast = CntW'(NUM_TAP);
  localparam logic [CntW-1:0] TapCnt  = CntW'(NUM_TAP);

  typedef enum logic [2:0] {StIdle, StClear, StWaitIn, StMac, StOut, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       head_q, head_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic                  final_idx;
  logic [CntW-1:0]       data_idx;
  logic [DATA_WIDTH-1:0] prod;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(logic [CntW-1:0] idx);
    return ADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign final_idx = (out_cnt_q == len_q - 32'd1);
  // Newest sample sits at head; tap k pairs with the sample k positions older.
  assign data_idx  = (head_q >= cnt_q) ? head_q - cnt_q : head_q + TapCnt - cnt_q;
  // Low DATA_WIDTH bits of a signed product equal those of the unsigned product.
  assign prod      = bus.tap_rdo * bus.data_rdo;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    len_d      = len_q;
    out_cnt_d  = out_cnt_q;
    acc_d      = acc_q;
    res_d      = res_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = err_q;

    bus.ap_idle    = 1'b0;
    bus.ap_done    = 1'b0;
    bus.ss_tready  = 1'b0;
    bus.tap_re     = 1'b0;
    bus.tap_raddr  = '0;
    bus.data_re    = 1'b0;
    bus.data_raddr = '0;
    bus.data_we    = 1'b0;
    bus.data_waddr = '0;
    bus.data_wdi   = '0;

    unique case (state_q)
      StIdle: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) begin
          len_d     = bus.data_length;
          err_d     = 1'b0;
          out_cnt_d = '0;
          head_d    = '0;
          cnt_d     = '0;
          state_d   = StClear;
        end
      end
      StClear: begin
        bus.data_we    = 1'b1;
        bus.data_waddr = word_addr(cnt_q);
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = (len_q == 32'd0) ? StDone : StWaitIn;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIn: begin
        bus.ss_tready  = 1'b1;
        bus.data_we    = bus.ss_tvalid;
        bus.data_waddr = word_addr(head_q);
        bus.data_wdi   = bus.ss_tdata;
        if (bus.ss_tvalid) begin
          if (bus.ss_tlast != final_idx) err_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        // Read k is issued at cnt==k and its product is summed at cnt==k+1.
        if (cnt_q <= LastIdx) begin
          bus.tap_re     = 1'b1;
          bus.data_re    = 1'b1;
          bus.tap_raddr  = word_addr(cnt_q);
          bus.data_raddr = word_addr(data_idx);
        end
        if (cnt_q != '0) acc_d = acc_q + prod;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MacLast) begin
          res_d   = acc_q + prod;
          valid_d = 1'b1;
          last_d  = final_idx;
          cnt_d   = '0;
          state_d = StOut;
        end
      end
      StOut: begin
        if (bus.sm_tready) begin
          valid_d   = 1'b0;
          last_d    = 1'b0;
          out_cnt_d = out_cnt_q + 32'd1;
          head_d    = (head_q == LastIdx) ? '0 : head_q + 1'b1;
          state_d   = (out_cnt_q + 32'd1 == len_q) ? StDone : StWaitIn;
        end
      end
      StDone: begin
        bus.ap_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      head_q    <= '0;
      len_q     <= '0;
      out_cnt_q <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      len_q     <= len_d;
      out_cnt_q <= out_cnt_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign bus.sm_tvalid  = valid_q;
  assign bus.sm_tdata   = res_q;
  assign bus.sm_tlast   = last_q;
  assign bus.stream_err = err_q;

endmodule

// File: tb/tb_fir_bram_sequencer.sv
// Bench for fir_bram_sequencer: BRAM models around the DUT, a direct-form FIR reference
// over the run's sample history, a vector table and directed/random runs.
module tb_fir_bram_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_bram_sequencer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  fir_bram_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_TAP(11)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .bus        (bus)
  );

  logic [31:0] taps [11];
  logic [31:0] dmem [11];
  logic [31:0] xs   [64];
  logic [31:0] outs [64];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // Registered-read BRAM macros.
  always @(posedge clk) begin
    if (bus.tap_re)  bus.tap_rdo  <= taps[bus.tap_raddr[5:2]];
    if (bus.data_re) bus.data_rdo <= dmem[bus.data_raddr[5:2]];
    if (bus.data_we) dmem[bus.data_waddr[5:2]] <= bus.data_wdi;
  end

  always @(negedge clk) if (bus.ap_done) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // y[n] = sum_k tap[k]*x[n-k], zero history before the run, wrapped to 32 bits.
  function automatic logic [31:0] model(input int n);
    logic [31:0] s = 0;
    for (int k = 0; k < 11; k++)
      if (n - k >= 0) s = s + taps[k] * xs[n - k];
    return s;
  endfunction

  task automatic send(input logic [31:0] x, input logic lst, input int stall,
                      output logic [31:0] y, output logic yl, output int lat);
    int t = 0;
    bus.ss_tdata  = x;
    bus.ss_tlast  = lst;
    bus.ss_tvalid = 1'b1;
    while (!bus.ss_tready && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("ss_tready_seen", 32'(bus.ss_tready), 1);
    @(negedge clk);
    bus.ss_tvalid = 1'b0;
    lat = 0;
    while (!bus.sm_tvalid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    y  = bus.sm_tdata;
    yl = bus.sm_tlast;
    for (int s = 0; s < stall; s++) begin
      bus.ap_start = (s == 0);
      @(negedge clk);
      bus.ap_start = 1'b0;
      check("hold_valid", 32'(bus.sm_tvalid), 1);
      check("hold_data", bus.sm_tdata, y);
      check("no_ss_ready_in_out", 32'(bus.ss_tready), 0);
    end
    bus.sm_tready = 1'b1;
    @(negedge clk);
    bus.sm_tready = 1'b0;
  endtask

  // stall < 0 selects a random 0..3 cycle ready delay per output.
  task automatic run(input int len, input int bad_last, input int stall);
    int done0, lat, st;
    logic [31:0] y;
    logic yl, lst;
    done0 = done_cnt;
    @(negedge clk);
    check("idle_before_start", 32'(bus.ap_idle), 1);
    bus.data_length = len;
    bus.ap_start    = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    check("err_cleared_by_start", 32'(bus.stream_err), 0);
    check("busy_after_start", 32'(bus.ap_idle), 0);
    for (int i = 0; i < len; i++) begin
      lst = (i == len - 1) ^ (i == bad_last);
      st  = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      send(xs[i], lst, st, y, yl, lat);
      outs[i] = y;
      check("sm_tdata", y, model(i));
      check("sm_tlast", 32'(yl), 32'(i == len - 1));
      check("latency", lat, 12);
    end
    repeat ((len == 0) ? 16 : 3) @(negedge clk);
    check("ap_done_pulses", done_cnt - done0, 1);
    check("idle_after_run", 32'(bus.ap_idle), 1);
    check("stream_err", 32'(bus.stream_err), 32'(bad_last >= 0));
  endtask

  typedef struct {
    logic [31:0] tap0;
    logic [31:0] tapr;
    logic [31:0] x;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   t_cnt;

  initial begin
    vecs[0] = '{tap0: 32'd1,          tapr: 32'd1, x: 32'd7,          exp: 32'd7};
    vecs[1] = '{tap0: 32'h7FFF_FFFF,  tapr: 32'd0, x: 32'd2,          exp: 32'hFFFF_FFFE};
    vecs[2] = '{tap0: 32'd3,          tapr: 32'd0, x: 32'hFFFF_FFFF,  exp: 32'hFFFF_FFFD};
    vecs[3] = '{tap0: 32'd5,          tapr: 32'd9, x: 32'hFFFF_FFFD,  exp: 32'hFFFF_FFF1};
    vecs[4] = '{tap0: 32'h0001_0000,  tapr: 32'd9, x: 32'h0001_0000,  exp: 32'd0};

    rst_n = 1'b0;
    bus.ap_start = 0; bus.data_length = 0;
    bus.ss_tvalid = 0; bus.ss_tdata = 0; bus.ss_tlast = 0; bus.sm_tready = 0;
    repeat (2) @(negedge clk);
    check("rst_ap_idle", 32'(bus.ap_idle), 1);
    check("rst_ss_tready", 32'(bus.ss_tready), 0);
    check("rst_sm_tvalid", 32'(bus.sm_tvalid), 0);
    check("rst_sm_tdata", bus.sm_tdata, 0);
    check("rst_data_we", 32'(bus.data_we), 0);
    check("rst_tap_re", 32'(bus.tap_re), 0);
    rst_n = 1'b1;

    // Taps all 1, ramp input.
    for (int k = 0; k < 11; k++) taps[k] = 1;
    for (int i = 0; i < 5; i++) xs[i] = i + 1;
    run(5, -1, 0);
    check("ramp_out0", outs[0], 1);
    check("ramp_out2", outs[2], 6);
    check("ramp_out4", outs[4], 15);

    // Single-output vectors; nonzero outer taps expose any stale data left in RAM.
    foreach (vecs[v]) begin
      taps[0] = vecs[v].tap0;
      for (int k = 1; k < 11; k++) taps[k] = vecs[v].tapr;
      xs[0] = vecs[v].x;
      run(1, -1, 0);
      check("vec_out", outs[0], vecs[v].exp);
    end

    // Impulse response with stalled downstream.
    for (int k = 0; k < 11; k++) taps[k] = k + 1;
    for (int i = 0; i < 13; i++) xs[i] = (i == 0) ? 1 : 0;
    run(13, -1, 5);
    for (int i = 0; i < 13; i++) check("impulse", outs[i], (i < 11) ? i + 1 : 0);

    // Constant input through head wrap.
    for (int k = 0; k < 11; k++) taps[k] = 1;
    for (int i = 0; i < 30; i++) xs[i] = 2;
    run(30, -1, -1);
    for (int i = 0; i < 30; i++) check("const2", outs[i], (i < 11) ? 2 * (i + 1) : 22);

    run(0, -1, 0);

    // Reset during MAC aborts immediately.
    @(negedge clk);
    bus.data_length = 5;
    bus.ap_start    = 1'b1;
    @(negedge clk);
    bus.ap_start  = 1'b0;
    bus.ss_tdata  = 7;
    bus.ss_tlast  = 0;
    bus.ss_tvalid = 1'b1;
    t_cnt = 0;
    while (!bus.ss_tready && t_cnt < 64) begin
      @(negedge clk);
      t_cnt++;
    end
    @(negedge clk);
    bus.ss_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("in_mac_tap_re", 32'(bus.tap_re), 1);
    rst_n = 1'b0;
    #1;
    check("abort_ap_idle", 32'(bus.ap_idle), 1);
    check("abort_tap_re", 32'(bus.tap_re), 0);
    check("abort_data_re", 32'(bus.data_re), 0);
    check("abort_tap_raddr", 32'(bus.tap_raddr), 0);
    check("abort_sm_tdata", bus.sm_tdata, 0);
    check("abort_ss_tready", 32'(bus.ss_tready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery run with ss_tlast wrongly on sample 2 of 5.
    for (int k = 0; k < 11; k++) taps[k] = k + 2;
    for (int i = 0; i < 5; i++) xs[i] = 10 * (i + 1);
    run(5, 1, 0);
    run(1, -1, 0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      int len, bad;
      len = $urandom_range(1, 16);
      bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int k = 0; k < 11; k++) taps[k] = (r < 3) ? $urandom_range(0, 255) - 128 : $urandom;
      for (int i = 0; i < len; i++) xs[i] = (r < 3) ? $urandom_range(0, 1023) - 512 : $urandom;
      run(len, bad, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_bram_sequencer.md
Name: fir_bram_sequencer

Overview:
- Initiator side for the single-port-read/single-port-write BRAM macros (1-cycle registered read, byte addressing, word index = addr>>2).
- Accepts input samples on an AXI-Stream slave and writes them into an 11-entry circular data RAM.
- Sweeps the tap RAM and data RAM to compute an 11-tap FIR output, then emits it on an AXI-Stream master.
- Sits between the user-project AXI-Stream ports and two BRAM instances (tap, data) inside the Caravel FIR user block.

Parameters:
ADDR_WIDTH, 12, BRAM byte-address width
DATA_WIDTH, 32, sample/tap/result width
NUM_TAP, 11, taps and data-RAM depth

Ports:
axis_clk  in  1  sole clock
axis_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  one-cycle start pulse; ignored unless idle
data_length  in  32  number of samples/outputs this run
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse at end of run
ss_tvalid  in  1  input sample valid
ss_tdata  in  DATA_WIDTH  input sample, signed
ss_tlast  in  1  input last marker (checked only)
ss_tready  out  1  sample accepted when ss_tvalid&ss_tready
sm_tvalid  out  1  output valid
sm_tdata  out  DATA_WIDTH  FIR result
sm_tlast  out  1  high with the final output of the run
sm_tready  in  1  downstream ready
stream_err  out  1  sticky: ss_tlast disagreed with data_length; cleared by ap_start
tap_re  out  1  tap RAM read enable
tap_raddr  out  ADDR_WIDTH  tap RAM byte read address
tap_rdo  in  DATA_WIDTH  tap RAM data (valid one edge after tap_re)
data_we  out  1  data RAM write enable
data_waddr  out  ADDR_WIDTH  data RAM byte write address
data_wdi  out  DATA_WIDTH  data RAM write data
data_re  out  1  data RAM read enable
data_raddr  out  ADDR_WIDTH  data RAM byte read address
data_rdo  in  DATA_WIDTH  data RAM read data

Behaviour:
- Reset (async, axis_rst_n=0): state IDLE, ap_idle=1; ap_done, ss_tready, sm_tvalid, sm_tlast, stream_err, tap_re, data_re, data_we = 0; sm_tdata, all addresses, data_wdi, accumulator, head pointer, output counter = 0. Reset mid-run aborts immediately. RAM contents are not touched.
- All addresses are 4*index, index in 0..NUM_TAP-1.
- States:
  - IDLE: waits for ap_start. On ap_start: latch data_length, clear stream_err and counter, set head=0, go to CLEAR.
  - CLEAR: data_we=1, data_wdi=0, addresses 0,4,...,40 over 11 cycles. Then WAIT_IN, or DONE if data_length==0.
  - WAIT_IN: ss_tready=1. On handshake (edge E0): data_we=1 with data_waddr=4*head, data_wdi=ss_tdata in that same cycle; go to MAC.
  - MAC: for k=0..10, one per cycle, tap_re=data_re=1, tap_raddr=4*k, data_raddr=4*((head-k) mod 11). The read issued in the cycle after E0 returns at E1; k=10 returns at E11. Accumulator adds low 32 bits of the signed product tap_rdo*data_rdo at E2..E12, starting from 0; all sums wrap mod 2^32. At E12, sm_tdata is loaded with the final sum, sm_tvalid=1, and the state goes to OUT.
  - OUT: hold sm_tvalid, sm_tdata, sm_tlast stable until sm_tready. On handshake: counter++, head = (head+1) mod 11 (wrap 10->0). Go to DONE if counter reached data_length, else WAIT_IN. ss_tready=0 throughout MAC and OUT.
  - DONE: ap_done=1 for exactly one cycle, then IDLE.
- sm_tlast=1 iff the output index == data_length-1.
- stream_err set if ss_tlast=1 on a non-final accepted sample, or ss_tlast=0 on the final one. It does not alter the flow.
- ap_start outside IDLE is ignored.
- Write and read never target the same word in the same cycle, because the write occurs only in the E0 cycle.

Test Plan:
- taps all 1, data_length=5, inputs 1,2,3,4,5 -> sm_tdata 1,3,6,10,15; sm_tlast only on 15; one ap_done pulse; stream_err=0 when ss_tlast is on the 5th sample.
- taps tap[k]=k+1, data_length=13, input 1 then zeros -> outputs 1..11, then 0, 0; sm_tvalid rises on the 12th edge after each accepting edge.
- taps all 1, data_length=30, constant input 2 -> 2,4,...,22, then 22 steady through head wrap (10->0) and beyond.
- tap[0]=0x7FFFFFFF, others 0, input 2 -> 0xFFFFFFFE (wrap, no saturation); input -1 with tap[0]=3 -> 0xFFFFFFFD.
- sm_tready held low 5 cycles in OUT -> sm_tdata/sm_tvalid stable, ss_tready=0; second run after ap_start shows no stale samples from run 1 (CLEAR zeroes RAM).
- axis_rst_n pulsed low during MAC -> all outputs at reset values immediately; a subsequent run produces correct results; ss_tlast on sample 2 of 5 -> stream_err=1 until next ap_start.
